// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM round-robin arbiter.
// tag_t index is sized for the largest legal requester count (8).
package sram_arb_pkg;
    localparam int MAX_RD_LAT = 4;
    localparam int MAX_REQ    = 8;
    localparam int TAG_IDX_W  = $clog2(MAX_REQ);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic          found;
    logic [IW-1:0] j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (en && !found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = j;
            end
        end
    end
endmodule

// File: rtl/sram_if_arbiter.sv
// Shares one single-port SRAM among NUM_REQ requesters; read data is routed
// back through a tag pipeline matched to RD_LAT, with a flush/drain handshake.
module sram_if_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         start_addr,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      sram_en,
    output logic                      sram_we,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    input  logic [DATA_W-1:0]         sram_rdata,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      busy
);
    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STAGES = RD_LAT + 1;

    arb_state_e                state_q, state_d;
    logic [IW-1:0]             ptr_q, ptr_d;
    logic                      sram_en_q, sram_en_d;
    logic                      sram_we_q, sram_we_d;
    logic [ADDR_W-1:0]         sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]         sram_wdata_q, sram_wdata_d;
    tag_t [STAGES-1:0]         tag_q, tag_d;

    logic [NUM_REQ-1:0]        gnt;
    logic [IW-1:0]             gnt_idx;
    logic                      gnt_en;
    logic                      accept;
    logic                      upstream_busy;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (gnt_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_en    = (state_q == RUN) && !flush;
    assign accept    = |gnt;
    assign req_ready = gnt;

    always_comb begin
        ptr_d        = ptr_q;
        sram_en_d    = accept;
        sram_we_d    = accept && req_we[gnt_idx];
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if (accept) begin
            ptr_d        = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            sram_addr_d  = start_addr + req_addr[gnt_idx*ADDR_W +: ADDR_W];
            sram_wdata_d = req_wdata[gnt_idx*DATA_W +: DATA_W];
        end
    end

    // Only reads enter the tag pipe; the last stage lines up with sram_rdata.
    always_comb begin
        tag_d[0].valid = accept && !req_we[gnt_idx];
        tag_d[0].idx   = TAG_IDX_W'(gnt_idx);
        for (int s = 1; s < STAGES; s++) tag_d[s] = tag_q[s-1];
    end

    always_comb begin
        busy          = 1'b0;
        upstream_busy = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            busy = busy | tag_q[s].valid;
            if (s < STAGES - 1) upstream_busy = upstream_busy | tag_q[s].valid;
        end
    end

    // DRAIN exits once nothing but the final (currently responding) stage is
    // occupied, so flush_done lands the cycle after the last rsp_valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   if (!upstream_busy) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            ptr_q        <= '0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            tag_q        <= tag_d;
        end
    end

    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign flush_done = (state_q == DONE);
    assign rsp_rdata  = sram_rdata;
    assign rsp_valid  = tag_q[STAGES-1].valid ? (NUM_REQ'(1) << tag_q[STAGES-1].idx) : '0;
endmodule

// File: tb/tb_sram_if_arbiter.sv
// Directed bench: three arbiters (RD_LAT 1..3) share stimulus; each check
// targets the instance whose latency the scenario calls for.
module tb_sram_if_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [AW-1:0]     start_addr;
    logic [N-1:0]      req_valid, req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     sram_rdata;

    logic [N-1:0]      rdy   [1:3];
    logic [N-1:0]      rsp   [1:3];
    logic [DW-1:0]     rdata [1:3];
    logic              en    [1:3];
    logic              we    [1:3];
    logic [AW-1:0]     addr  [1:3];
    logic [DW-1:0]     wdata [1:3];
    logic              fdone [1:3];
    logic              busy  [1:3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        sram_if_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(g)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start_addr (start_addr),
            .req_valid  (req_valid),
            .req_ready  (rdy[g]),
            .req_we     (req_we),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .rsp_valid  (rsp[g]),
            .rsp_rdata  (rdata[g]),
            .sram_en    (en[g]),
            .sram_we    (we[g]),
            .sram_addr  (addr[g]),
            .sram_wdata (wdata[g]),
            .sram_rdata (sram_rdata),
            .flush      (flush),
            .flush_done (fdone[g]),
            .busy       (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_off(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0; req_we = '0;
        req_addr = '0; req_wdata = '0; start_addr = 32'h1234;
        sram_rdata = 32'hCAFE_F00D;
        step(); step();
        chk("rst_en",    en[1],    0);
        chk("rst_busy",  busy[1],  0);
        chk("rst_rsp",   rsp[1],   0);
        chk("rst_fdone", fdone[1], 0);
        rst = 1'b0;

        // fairness: everyone requests, grants rotate 0..3 twice
        for (int i = 0; i < N; i++) set_off(i, 32'(4 * i));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_rdy", rdy[1], 64'd1 << (k % 4));
            step();
            chk("fair_en",   en[1],   1);
            chk("fair_addr", addr[1], 32'h1234 + 32'(4 * (k % 4)));
            if (k >= 1) begin
                chk("fair_rsp",   rsp[1],   64'd1 << ((k - 1) % 4));
                chk("fair_rdata", rdata[1], 32'hCAFE_F00D);
            end
        end
        req_valid = '0;
        step();
        chk("fair_en_off",  en[1],  0);
        chk("fair_rsp_end", rsp[1], 4'b1000);
        step();

        // single read by requester 2, offset 8
        set_off(2, 32'h8);
        req_valid = 4'b0100;
        #1;
        chk("rd_rdy", rdy[1], 4'b0100);
        step();
        req_valid = '0;
        chk("rd_en",   en[1],   1);
        chk("rd_we",   we[1],   0);
        chk("rd_addr", addr[1], 32'h123C);
        chk("rd_busy", busy[1], 1);
        chk("rd_rsp0", rsp[1],  0);
        step();
        chk("rd_rsp",   rsp[1],   4'b0100);
        chk("rd_rdata", rdata[1], 32'hCAFE_F00D);
        chk("rd_en1",   en[1],    0);

        // write by requester 1: no response
        set_off(1, 32'h0);
        req_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
        req_we = 4'b0010; req_valid = 4'b0010;
        #1;
        chk("wr_rdy", rdy[1], 4'b0010);
        step();
        req_valid = '0; req_we = '0;
        chk("wr_en",    en[1],    1);
        chk("wr_we",    we[1],    1);
        chk("wr_addr",  addr[1],  32'h1234);
        chk("wr_wdata", wdata[1], 32'hDEAD_BEEF);
        chk("wr_busy",  busy[1],  0);
        step();
        chk("wr_rsp1", rsp[1], 0);
        step();
        chk("wr_rsp2", rsp[1], 0);

        // address wrap
        start_addr = 32'hFFFF_FFF0;
        set_off(0, 32'h20);
        req_valid = 4'b0001;
        #1;
        chk("wrap_rdy", rdy[1], 4'b0001);
        step();
        req_valid = '0;
        start_addr = 32'h1234;
        chk("wrap_addr", addr[1], 32'h0000_0010);
        step(); step(); step(); step();

        // flush drain on the RD_LAT=3 instance
        req_valid = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fl_rdy", rdy[3], 64'd2 << k);
            step();
        end
        flush = 1'b1; req_valid = 4'hF;
        #1;
        chk("fl_same_rdy", rdy[3],   0);
        chk("fl_fdone0",   fdone[3], 0);
        step();
        flush = 1'b0;
        chk("fl_rdy3", rdy[3], 0);
        chk("fl_rsp3", rsp[3], 4'b0010);
        step();
        chk("fl_rdy4", rdy[3], 0);
        chk("fl_rsp4", rsp[3], 4'b0100);
        step();
        chk("fl_rsp5",   rsp[3],   4'b1000);
        chk("fl_fdone5", fdone[3], 0);
        step();
        chk("fl_fdone6", fdone[3], 1);
        chk("fl_busy6",  busy[3],  0);
        chk("fl_rdy6",   rdy[3],   0);
        chk("fl_rsp6",   rsp[3],   0);
        step();
        chk("fl_fdone7", fdone[3], 0);
        chk("fl_resume", rdy[3],   4'b0001);
        req_valid = '0;

        // reset one cycle after a read is accepted (RD_LAT=2)
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("rr_rdy", rdy[2], 4'b0001);
        step();
        req_valid = '0;
        rst = 1'b1;
        chk("rr_busy_pre", busy[2], 1);
        step();
        rst = 1'b0;
        chk("rr_busy", busy[2], 0);
        chk("rr_rsp0", rsp[2],  0);
        step();
        chk("rr_rsp1", rsp[2], 0);
        step();
        chk("rr_rsp2", rsp[2], 0);
        req_valid = 4'hF;
        #1;
        chk("rr_ptr", rdy[2], 4'b0001);
        req_valid = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
